// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/exception sequencer and the PC-select mux.
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, EXC = 1'b1} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_IRQ   = 2'b01;
  localparam logic [1:0] CAUSE_BADOP = 2'b10;

  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;
endpackage

// File: rtl/irq_edge_latch.sv
// Samples irq, detects its rising edge and holds a pending flag until serviced.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pending
);
  logic irq_q, irq_d;
  logic pend_q, pend_d;

  // A new edge in the same cycle as a service beats the clear.
  always_comb begin
    irq_d  = irq;
    pend_d = (irq & ~irq_q) | (pend_q & ~clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use/branch/jump pipeline control plus precise irq and bad-opcode takes at ID.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16,
  parameter int KBIT  = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_bad_op,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             irq,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             exc_take,
  output logic [1:0]       exc_cause,
  output logic [PC_W-1:0]  epc,
  output logic             irq_pending,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t            state_q, state_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu, ok, take_irq, take_bad;

  irq_edge_latch u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .clr     (take_irq),
    .pending (irq_pending)
  );

  always_comb begin
    lu = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    ok = (state_q == RUN) && id_valid && !id_pc[KBIT] && !ex_branch_taken && !lu;
    take_irq = ok && irq_pending;
    take_bad = ok && id_bad_op && !irq_pending;

    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    exc_take    = 1'b0;
    cnt_d       = cnt_q;
    if (take_irq || take_bad) begin
      exc_take    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end

    epc_d   = epc_q;
    cause_d = cause_q;
    if (take_irq) begin
      epc_d   = id_pc;
      cause_d = CAUSE_IRQ;
    end else if (take_bad) begin
      epc_d   = id_pc + PC_W'(4);
      cause_d = CAUSE_BADOP;
    end

    state_d = state_q;
    case (state_q)
      RUN: if (exc_take) state_d = EXC;
      EXC: if (id_valid && id_pc[KBIT]) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exc_cause = cause_q;
  assign epc       = epc_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: combinational priority table, then irq/bad-opcode/reset sequences.
module tb_hazard_ctrl;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_jump, id_bad_op;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, ex_branch_taken, irq;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, exc_take;
  logic [1:0]  exc_cause;
  logic [31:0] epc;
  logic        irq_pending;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.PC_W(32), .CNT_W(CNT_W), .KBIT(31)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_bad_op(id_bad_op), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .irq(irq),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .exc_take(exc_take), .exc_cause(exc_cause),
    .epc(epc), .irq_pending(irq_pending), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [31:0] pc; logic [4:0] rs, rt; logic urs, urt, jmp, bad, mr;
    logic [4:0] exrt; logic br;
    logic [4:0] exp; // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, exc_take}
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 32'h0040_0000; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_bad_op = 0;
    ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, exc_take};
  endfunction

  task automatic set_id(input logic [31:0] pc, input logic bad);
    idle(); id_valid = 1; id_pc = pc; id_bad_op = bad;
  endtask

  initial begin
    idle(); irq = 0; reset = 1;
    #12;
    chk("reset_outs", {27'd0, outs()}, 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_cause", {30'd0, exc_cause}, 32'd0);
    chk("reset_pend", {31'd0, irq_pending}, 32'd0);
    chk("reset_cnt", {30'd0, stall_cnt}, 32'd0);
    reset = 0;
    tick();

    //         v  pc            rs rt urs urt jmp bad mr exrt br  exp
    tbl[0]  = '{0, 32'h00400000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000};
    tbl[1]  = '{1, 32'h00400000, 8, 3, 1, 1, 0, 0, 1, 8, 0, 5'b11010};
    tbl[2]  = '{1, 32'h00400004, 4, 9, 1, 1, 0, 0, 1, 9, 0, 5'b11010};
    tbl[3]  = '{1, 32'h00400008, 4, 9, 1, 0, 0, 0, 1, 9, 0, 5'b00000};
    tbl[4]  = '{1, 32'h0040000c, 0, 0, 1, 1, 0, 0, 1, 0, 0, 5'b00000};
    tbl[5]  = '{0, 32'h00400010, 8, 0, 1, 0, 0, 0, 1, 8, 0, 5'b00000};
    tbl[6]  = '{1, 32'h00400014, 8, 0, 1, 0, 0, 0, 1, 8, 1, 5'b00110};
    tbl[7]  = '{1, 32'h00400018, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00100};
    tbl[8]  = '{1, 32'h0040001c, 7, 0, 1, 0, 1, 0, 1, 7, 0, 5'b11010};
    tbl[9]  = '{1, 32'h00400020, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00110};
    tbl[10] = '{1, 32'h80000100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000};
    tbl[11] = '{1, 32'h00400024, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00110};
    tbl[12] = '{1, 32'h00400028, 5, 0, 1, 0, 0, 1, 1, 5, 0, 5'b11010};

    for (int i = 0; i < 13; i++) begin
      id_valid = tbl[i].v; id_pc = tbl[i].pc; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
      id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; id_jump = tbl[i].jmp;
      id_bad_op = tbl[i].bad; ex_mem_read = tbl[i].mr; ex_rt = tbl[i].exrt;
      ex_branch_taken = tbl[i].br;
      #1;
      chk($sformatf("vec%0d_outs", i), {27'd0, outs()}, {27'd0, tbl[i].exp});
      if (tbl[i].exp[4] && exp_cnt < 3) exp_cnt++;
      tick();
      chk($sformatf("vec%0d_cnt", i), {30'd0, stall_cnt}, exp_cnt);
    end
    idle();

    // Load-use lasts one cycle: next cycle the lw has moved to MEM.
    id_valid = 1; id_rs = 8; id_uses_rs = 1;
    tick();
    chk("lu_gone_stall", {31'd0, pc_stall}, 32'd0);

    // Irq take
    idle(); irq = 1; tick(); irq = 0;
    chk("irq_pend_set", {31'd0, irq_pending}, 32'd1);
    set_id(32'h00400010, 0); #1;
    chk("irq_take", {27'd0, outs()}, 32'b00111);
    tick();
    chk("irq_epc", epc, 32'h00400010);
    chk("irq_cause", {30'd0, exc_cause}, 32'd1);
    chk("irq_pend_clr", {31'd0, irq_pending}, 32'd0);
    set_id(32'h00400014, 1); #1;
    chk("exc_no_take", {31'd0, exc_take}, 32'd0);
    tick();
    set_id(32'h80000004, 0); tick();

    // Bad opcode, user then kernel
    set_id(32'h00400100, 1); #1;
    chk("bad_take", {31'd0, exc_take}, 32'd1);
    tick();
    chk("bad_epc", epc, 32'h00400104);
    chk("bad_cause", {30'd0, exc_cause}, 32'd2);
    set_id(32'h80000008, 0); tick();
    set_id(32'h80000100, 1); #1;
    chk("bad_kernel", {31'd0, exc_take}, 32'd0);
    tick();

    // Irq deferral through kernel mode and a branch flush
    set_id(32'h80000020, 0); irq = 1; #1;
    chk("defer_k0_take", {31'd0, exc_take}, 32'd0);
    tick(); irq = 0; #1;
    chk("defer_k1_take", {31'd0, exc_take}, 32'd0);
    tick();
    chk("defer_pend", {31'd0, irq_pending}, 32'd1);
    set_id(32'h00400200, 0); ex_branch_taken = 1; #1;
    chk("defer_br", {27'd0, outs()}, 32'b00110);
    tick();
    chk("defer_pend_br", {31'd0, irq_pending}, 32'd1);
    set_id(32'h00400200, 0); #1;
    chk("defer_take", {31'd0, exc_take}, 32'd1);
    tick();
    chk("defer_epc", epc, 32'h00400200);

    // Now in EXC: raise a pending irq, then reset asynchronously mid-cycle
    idle(); irq = 1; tick(); irq = 0;
    chk("exc_pend", {31'd0, irq_pending}, 32'd1);
    #2; reset = 1; #1;
    chk("rst_pend", {31'd0, irq_pending}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", {30'd0, exc_cause}, 32'd0);
    chk("rst_cnt", {30'd0, stall_cnt}, 32'd0);
    chk("rst_outs", {27'd0, outs()}, 32'd0);
    tick(); reset = 0; tick();
    set_id(32'h00400300, 0); #1;
    chk("post_rst_no_take", {31'd0, exc_take}, 32'd0);
    tick();
    idle(); irq = 1; tick(); irq = 0;
    set_id(32'h00400304, 0); #1;
    chk("post_rst_take", {31'd0, exc_take}, 32'd1);
    tick();
    chk("post_rst_epc", epc, 32'h00400304);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
